// File: rtl/la_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : la_capture_ctrl
// Purpose  : Logic-analyzer capture controller. After an arm request it
//            clears the capture memory, then records the probe bus into a
//            circular pre-trigger queue (lines 0..BT_LEN-1). On a masked
//            trigger match it stores the trigger sample at line BT_LEN and
//            fills lines BT_LEN+1..2^ADDR_W-2 with run-length-encoded
//            samples. The last memory line receives the pre-trigger tail
//            pointer so replay can unroll the circular queue.
//            Memory line format: {rep_count[REP_W], sample[DATA_W]};
//            rep_count == 0 marks an unused line.
//
// Ports    : clk             sampling clock
//            rst_l           asynchronous active-low reset
//            arm             single-cycle start request (IDLE/DONE only)
//            data_in         probe bus
//            trig_value      trigger compare value
//            trig_mask       trigger bit mask (1 = bit compared)
//            mem_we          capture memory write strobe
//            mem_addr        capture memory write address
//            mem_wdata       capture memory write data {rep_count, sample}
//            trigger_matched high from the trigger-sample write until re-arm
//            busy            high in CLEAR, PRETRIG, POSTTRIG, TAIL
//            done            high in DONE
//
// Revision : 1.0 - initial release
// ============================================================================
module la_capture_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6,
  parameter int REP_W  = 8,
  parameter int BT_LEN = 8
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     arm,
  input  logic [DATA_W-1:0]        data_in,
  input  logic [DATA_W-1:0]        trig_value,
  input  logic [DATA_W-1:0]        trig_mask,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [REP_W+DATA_W-1:0]  mem_wdata,
  output logic                     trigger_matched,
  output logic                     busy,
  output logic                     done
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [ADDR_W-1:0] c_last_addr = {ADDR_W{1'b1}};           // tail line
  localparam logic [ADDR_W-1:0] c_post_end  = c_last_addr - ADDR_W'(1); // last RLE line
  localparam logic [ADDR_W-1:0] c_bt_last   = ADDR_W'(BT_LEN - 1);
  localparam logic [ADDR_W-1:0] c_bt_base   = ADDR_W'(BT_LEN);          // trigger line
  localparam logic [REP_W-1:0]  c_rep_max   = {REP_W{1'b1}};
  localparam logic [REP_W-1:0]  c_rep_one   = REP_W'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLEAR    = 3'd1,
    S_PRETRIG  = 3'd2,
    S_POSTTRIG = 3'd3,
    S_TAIL     = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t              r_state;
  logic [ADDR_W-1:0]   r_clr_cnt;  // clear sweep address
  logic [ADDR_W-1:0]   r_ptr;      // line currently holding the last sample
  logic [ADDR_W-1:0]   r_tail;     // newest pre-trigger line
  logic [DATA_W-1:0]   r_last;     // last stored sample
  logic [REP_W-1:0]    r_rep;      // repeat count of the line at r_ptr
  logic                r_have;     // a sample is available for RLE merging

  // Next-state / next-output values
  state_t              w_state;
  logic [ADDR_W-1:0]   w_clr_cnt;
  logic [ADDR_W-1:0]   w_ptr;
  logic [ADDR_W-1:0]   w_tail;
  logic [DATA_W-1:0]   w_last;
  logic [REP_W-1:0]    w_rep;
  logic                w_have;
  logic                w_we;
  logic [ADDR_W-1:0]   w_addr;
  logic [REP_W+DATA_W-1:0] w_wdata;
  logic                w_trig;
  logic                w_busy;
  logic                w_done;

  // Helper terms
  logic                w_match;    // masked trigger compare
  logic                w_same;     // sample can be merged into current line
  logic [ADDR_W-1:0]   w_pre_next; // next line in the circular pre-trigger queue

  assign w_match    = (((data_in ^ trig_value) & trig_mask) == '0);
  assign w_same     = r_have && (data_in == r_last) && (r_rep != c_rep_max);
  assign w_pre_next = (r_ptr == c_bt_last) ? '0 : (r_ptr + ADDR_W'(1));

  // --------------------------------------------------------------------------
  // State register and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state         <= S_IDLE;
      r_clr_cnt       <= '0;
      r_ptr           <= '0;
      r_tail          <= '0;
      r_last          <= '0;
      r_rep           <= '0;
      r_have          <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      trigger_matched <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      r_state         <= w_state;
      r_clr_cnt       <= w_clr_cnt;
      r_ptr           <= w_ptr;
      r_tail          <= w_tail;
      r_last          <= w_last;
      r_rep           <= w_rep;
      r_have          <= w_have;
      mem_we          <= w_we;
      mem_addr        <= w_addr;
      mem_wdata       <= w_wdata;
      trigger_matched <= w_trig;
      busy            <= w_busy;
      done            <= w_done;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state   = r_state;
    w_clr_cnt = r_clr_cnt;
    w_ptr     = r_ptr;
    w_tail    = r_tail;
    w_last    = r_last;
    w_rep     = r_rep;
    w_have    = r_have;
    w_we      = 1'b0;
    w_addr    = mem_addr;
    w_wdata   = mem_wdata;
    w_trig    = trigger_matched;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (arm) begin
          w_state   = S_CLEAR;
          w_trig    = 1'b0;
          w_clr_cnt = '0;
          // Starting the pointer on the last queue line makes the first
          // pre-trigger sample land on line 0, and leaves the tail at
          // BT_LEN-1 if the trigger fires immediately.
          w_ptr     = c_bt_last;
          w_tail    = c_bt_last;
          w_rep     = '0;
          w_last    = '0;
          w_have    = 1'b0;
        end
      end

      S_CLEAR: begin
        w_we      = 1'b1;
        w_addr    = r_clr_cnt;
        w_wdata   = '0;
        w_clr_cnt = r_clr_cnt + ADDR_W'(1);
        if (r_clr_cnt == c_last_addr) begin
          w_state = S_PRETRIG;
        end
      end

      S_PRETRIG: begin
        if (w_match) begin
          // Trigger sample always gets its own line; clearing r_have keeps
          // the first post-trigger sample from merging into it.
          w_we    = 1'b1;
          w_addr  = c_bt_base;
          w_wdata = {c_rep_one, data_in};
          w_ptr   = c_bt_base;
          w_rep   = c_rep_one;
          w_last  = data_in;
          w_have  = 1'b0;
          w_trig  = 1'b1;
          w_state = S_POSTTRIG;
        end else if (w_same) begin
          w_we    = 1'b1;
          w_addr  = r_ptr;
          w_wdata = {r_rep + REP_W'(1), data_in};
          w_rep   = r_rep + REP_W'(1);
          w_tail  = r_ptr;
        end else begin
          w_we    = 1'b1;
          w_addr  = w_pre_next;
          w_wdata = {c_rep_one, data_in};
          w_ptr   = w_pre_next;
          w_rep   = c_rep_one;
          w_last  = data_in;
          w_have  = 1'b1;
          w_tail  = w_pre_next;
        end
      end

      S_POSTTRIG: begin
        if (w_same) begin
          w_we    = 1'b1;
          w_addr  = r_ptr;
          w_wdata = {r_rep + REP_W'(1), data_in};
          w_rep   = r_rep + REP_W'(1);
        end else if (r_ptr == c_post_end) begin
          // Region full: this sample would need a new line, so drop it.
          w_state = S_TAIL;
        end else begin
          w_we    = 1'b1;
          w_addr  = r_ptr + ADDR_W'(1);
          w_wdata = {c_rep_one, data_in};
          w_ptr   = r_ptr + ADDR_W'(1);
          w_rep   = c_rep_one;
          w_last  = data_in;
          w_have  = 1'b1;
        end
      end

      S_TAIL: begin
        w_we    = 1'b1;
        w_addr  = c_last_addr;
        w_wdata = (REP_W + DATA_W)'(r_tail);
        w_state = S_DONE;
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase

    // Status flags follow the state being entered so they line up with
    // the registered write strobe.
    w_busy = (w_state == S_CLEAR)    || (w_state == S_PRETRIG) ||
             (w_state == S_POSTTRIG) || (w_state == S_TAIL);
    w_done = (w_state == S_DONE);
  end

endmodule
`default_nettype wire

// File: tb/tb_la_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_la_capture_ctrl
// Purpose  : Self-checking bench for la_capture_ctrl. A reference model
//            pushes the expected per-cycle output into a scoreboard queue as
//            each probe sample is driven; the entry is popped and compared
//            after the clock edge. Captured memory is rebuilt from the write
//            port and checked against fixed expected lines per scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_la_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        arm;
  logic [15:0] data_in;
  logic [15:0] trig_value;
  logic [15:0] trig_mask;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [23:0] mem_wdata;
  logic        trigger_matched;
  logic        busy;
  logic        done;

  la_capture_ctrl #(
    .DATA_W(16), .ADDR_W(6), .REP_W(8), .BT_LEN(8)
  ) dut (
    .clk(clk), .rst_l(rst_l), .arm(arm), .data_in(data_in),
    .trig_value(trig_value), .trig_mask(trig_mask),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .trigger_matched(trigger_matched), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [5:0]  addr;
    logic [23:0] wdata;
    logic        busy;
    logic        done;
    logic        trig;
  } obs_t;

  int n_pass  = 0;
  int n_total = 0;

  obs_t        exp_q[$];
  logic [23:0] mem_img [64];

  // ------------------------------------------------------------------
  // Reference model
  // ------------------------------------------------------------------
  localparam int PH_PRE = 0, PH_POST = 1, PH_TAIL = 2, PH_DONE = 3;
  int          m_phase;
  logic [5:0]  m_ptr, m_tail;
  logic [15:0] m_last;
  int          m_rep;
  bit          m_have, m_trig;

  task automatic model_start();
    m_phase = PH_PRE; m_ptr = 6'd7; m_tail = 6'd7;
    m_last = '0; m_rep = 0; m_have = 1'b0; m_trig = 1'b0;
  endtask

  task automatic model_step(input logic [15:0] d, input logic [15:0] tv,
                            input logic [15:0] tm, output obs_t e);
    e = '0;
    case (m_phase)
      PH_PRE: begin
        if (((d ^ tv) & tm) == 16'h0) begin
          e.we = 1'b1; e.addr = 6'd8; e.wdata = {8'd1, d};
          m_ptr = 6'd8; m_have = 1'b0; m_trig = 1'b1; m_phase = PH_POST;
        end else begin
          if (m_have && d == m_last && m_rep < 255) m_rep++;
          else begin
            m_ptr = (m_ptr == 6'd7) ? 6'd0 : m_ptr + 6'd1;
            m_rep = 1; m_last = d; m_have = 1'b1;
          end
          m_tail = m_ptr;
          e.we = 1'b1; e.addr = m_ptr; e.wdata = {8'(m_rep), d};
        end
      end
      PH_POST: begin
        if (m_have && d == m_last && m_rep < 255) begin
          m_rep++;
          e.we = 1'b1; e.addr = m_ptr; e.wdata = {8'(m_rep), d};
        end else if (m_ptr == 6'd62) begin
          m_phase = PH_TAIL;
        end else begin
          m_ptr = m_ptr + 6'd1; m_rep = 1; m_last = d; m_have = 1'b1;
          e.we = 1'b1; e.addr = m_ptr; e.wdata = {8'd1, d};
        end
      end
      PH_TAIL: begin
        e.we = 1'b1; e.addr = 6'd63; e.wdata = 24'(m_tail);
        m_phase = PH_DONE;
      end
      default: ;
    endcase
    e.busy = (m_phase != PH_DONE);
    e.done = (m_phase == PH_DONE);
    e.trig = m_trig;
  endtask

  // ------------------------------------------------------------------
  // Scenario stimulus
  // ------------------------------------------------------------------
  function automatic logic [15:0] data_for(input int scen, input int n);
    logic [7:0] a;
    a = n[7:0];
    case (scen)
      1: return {1'b0, a[7:1], a};
      2: return (n <= 515) ? 16'hAAAA : 16'(n);
      3: return (n < 20) ? 16'(n) : ((n == 20) ? 16'h8000 : 16'(n + 256));
      default: return 16'h1234 + 16'(n);
    endcase
  endfunction

  function automatic logic [15:0] tv_for(input int scen, input int n);
    case (scen)
      1: return 16'h0004;
      2: return (n == 3) ? 16'hAAAA : 16'h0000;
      3: return 16'h8000;
      default: return 16'h5555;
    endcase
  endfunction

  function automatic logic [15:0] tm_for(input int scen);
    case (scen)
      1: return 16'h00FF;
      2: return 16'hFFFF;
      3: return 16'hFFFF;
      default: return 16'h0000;
    endcase
  endfunction

  // Arms the DUT, checks the clear sweep, then runs samples until DONE
  // (or until stop_after samples when stop_after >= 0).
  task automatic capture(input int scen, input bit arm_noise, input int stop_after);
    obs_t e, o;
    int   n;
    for (int i = 0; i < 64; i++) mem_img[i] = 24'hDEADBE;
    arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
    n_total++;
    if ({mem_we, busy, done, trigger_matched} !== 4'b0100)
      $display("FAIL arm_accept scen %0d: got we/busy/done/trig=%b required 0100",
               scen, {mem_we, busy, done, trigger_matched});
    else n_pass++;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      n_total++;
      if (mem_we !== 1'b1 || mem_addr !== 6'(i) || mem_wdata !== 24'h0 || busy !== 1'b1)
        $display("FAIL clear[%0d] scen %0d: got we=%b addr=%0d wdata=%h busy=%b required we=1 addr=%0d wdata=0 busy=1",
                 i, scen, mem_we, mem_addr, mem_wdata, busy, i);
      else n_pass++;
      if (mem_we === 1'b1) mem_img[mem_addr] = mem_wdata;
    end
    model_start();
    n = 0;
    while (m_phase != PH_DONE) begin
      if (n >= 5000) begin
        n_total++;
        $display("FAIL timeout scen %0d: got no DONE after %0d samples required DONE", scen, n);
        break;
      end
      data_in    = data_for(scen, n);
      trig_value = tv_for(scen, n);
      trig_mask  = tm_for(scen);
      arm        = arm_noise && ((n % 7) == 3);
      model_step(data_in, trig_value, trig_mask, e);
      exp_q.push_back(e);
      @(posedge clk); #1;
      o.we    = mem_we;
      o.addr  = mem_we ? mem_addr : 6'h0;
      o.wdata = mem_we ? mem_wdata : 24'h0;
      o.busy  = busy;
      o.done  = done;
      o.trig  = trigger_matched;
      if (mem_we === 1'b1) mem_img[mem_addr] = mem_wdata;
      e = exp_q.pop_front();
      n_total++;
      if (o !== e)
        $display("FAIL sample[%0d] scen %0d: got we=%b addr=%0d wdata=%h busy=%b done=%b trig=%b required we=%b addr=%0d wdata=%h busy=%b done=%b trig=%b",
                 n, scen, o.we, o.addr, o.wdata, o.busy, o.done, o.trig,
                 e.we, e.addr, e.wdata, e.busy, e.done, e.trig);
      else n_pass++;
      n++;
      if (stop_after >= 0 && n == stop_after) begin
        arm = 1'b0;
        return;
      end
    end
    arm = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if ({mem_we, busy, done, trigger_matched} !== 4'b0011)
      $display("FAIL done_hold scen %0d: got we/busy/done/trig=%b required 0011",
               scen, {mem_we, busy, done, trigger_matched});
    else n_pass++;
  endtask

  // ------------------------------------------------------------------
  // Tests
  // ------------------------------------------------------------------
  task automatic test_reset();
    rst_l = 1'b1; arm = 1'b0; data_in = '0; trig_value = '0; trig_mask = '0;
    #2 rst_l = 1'b0;
    #10;
    n_total++;
    if ({mem_we, mem_addr, mem_wdata, trigger_matched, busy, done} !== 34'h0)
      $display("FAIL reset_values: got %h required 0",
               {mem_we, mem_addr, mem_wdata, trigger_matched, busy, done});
    else n_pass++;
    #10 rst_l = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if ({mem_we, busy, done} !== 3'b000)
      $display("FAIL idle_after_reset: got we/busy/done=%b required 000", {mem_we, busy, done});
    else n_pass++;
  endtask

  task automatic check_basic_image(input string tag);
    logic [23:0] pre [4];
    pre[0] = 24'h010000; pre[1] = 24'h010001; pre[2] = 24'h010102; pre[3] = 24'h010103;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (mem_img[i] !== pre[i])
        $display("FAIL %s line%0d: got %h required %h", tag, i, mem_img[i], pre[i]);
      else n_pass++;
    end
    for (int i = 4; i < 8; i++) begin
      n_total++;
      if (mem_img[i] !== 24'h0)
        $display("FAIL %s line%0d: got %h required 000000", tag, i, mem_img[i]);
      else n_pass++;
    end
    n_total++;
    if (mem_img[8] !== 24'h010204) $display("FAIL %s line8: got %h required 010204", tag, mem_img[8]);
    else n_pass++;
    n_total++;
    if (mem_img[62] !== 24'h011D3A) $display("FAIL %s line62: got %h required 011d3a", tag, mem_img[62]);
    else n_pass++;
    n_total++;
    if (mem_img[63] !== 24'h000003) $display("FAIL %s line63: got %h required 000003", tag, mem_img[63]);
    else n_pass++;
  endtask

  task automatic test_capture_basic();
    capture(1, 1'b0, -1);
    check_basic_image("basic");
  endtask

  task automatic test_rle_saturation();
    capture(2, 1'b0, -1);
    n_total++;
    if (mem_img[0] !== 24'h03AAAA) $display("FAIL rle line0: got %h required 03aaaa", mem_img[0]);
    else n_pass++;
    n_total++;
    if (mem_img[8] !== 24'h01AAAA) $display("FAIL rle line8: got %h required 01aaaa", mem_img[8]);
    else n_pass++;
    n_total++;
    if (mem_img[9] !== 24'hFFAAAA) $display("FAIL rle line9: got %h required ffaaaa", mem_img[9]);
    else n_pass++;
    n_total++;
    if (mem_img[10] !== 24'hFFAAAA) $display("FAIL rle line10: got %h required ffaaaa", mem_img[10]);
    else n_pass++;
    n_total++;
    if (mem_img[11] !== 24'h02AAAA) $display("FAIL rle line11: got %h required 02aaaa", mem_img[11]);
    else n_pass++;
    n_total++;
    if (mem_img[63] !== 24'h000000) $display("FAIL rle line63: got %h required 000000", mem_img[63]);
    else n_pass++;
  endtask

  task automatic test_pretrig_wrap();
    logic [23:0] want;
    capture(3, 1'b0, -1);
    for (int i = 0; i < 8; i++) begin
      want = (i < 4) ? (24'h010000 + 24'(16 + i)) : (24'h010000 + 24'(8 + i));
      n_total++;
      if (mem_img[i] !== want)
        $display("FAIL wrap line%0d: got %h required %h", i, mem_img[i], want);
      else n_pass++;
    end
    n_total++;
    if (mem_img[8] !== 24'h018000) $display("FAIL wrap line8: got %h required 018000", mem_img[8]);
    else n_pass++;
    n_total++;
    if (mem_img[63] !== 24'h000003) $display("FAIL wrap line63: got %h required 000003", mem_img[63]);
    else n_pass++;
  endtask

  task automatic test_mask_zero();
    capture(4, 1'b0, -1);
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (mem_img[i] !== 24'h0)
        $display("FAIL mask0 line%0d: got %h required 000000", i, mem_img[i]);
      else n_pass++;
    end
    n_total++;
    if (mem_img[8] !== 24'h011234) $display("FAIL mask0 line8: got %h required 011234", mem_img[8]);
    else n_pass++;
    n_total++;
    if (mem_img[63] !== 24'h000007) $display("FAIL mask0 line63: got %h required 000007", mem_img[63]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_capture();
    capture(1, 1'b0, 20);
    #3 rst_l = 1'b0;
    #1;
    n_total++;
    if ({mem_we, mem_addr, mem_wdata, trigger_matched, busy, done} !== 34'h0)
      $display("FAIL mid_reset_values: got %h required 0",
               {mem_we, mem_addr, mem_wdata, trigger_matched, busy, done});
    else n_pass++;
    #3 rst_l = 1'b1;
    @(posedge clk); #1;
    capture(1, 1'b0, -1);
    check_basic_image("rearm");
  endtask

  task automatic test_arm_ignored();
    capture(1, 1'b1, -1);
    check_basic_image("arm_noise");
  endtask

  initial begin
    test_reset();
    test_capture_basic();
    test_rle_saturation();
    test_pretrig_wrap();
    test_mask_zero();
    test_reset_mid_capture();
    test_arm_ignored();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
